// File: rtl/pcrc_generator.sv
// rtl/pcrc_generator.sv - CAN XL transmit preface CRC accumulator and serialiser
module pcrc_generator #(
  parameter logic [12:0] POLY       = 13'h1C1F,
  parameter logic [12:0] INIT       = 13'h0000,
  parameter bit          INCL_STUFF = 1'b1
) (
  input  logic        clk,
  input  logic        g_rst,
  input  logic        tx_start,
  input  logic        tx_bit_en,
  input  logic        tx_bit,
  input  logic        tx_stuff_bit,
  input  logic        pcrc_send,
  input  logic        act_err_frm_tx,
  input  logic        psv_err_frm_tx,
  input  logic        arb_lost,
  input  logic        tx_success,
  output logic [12:0] pcrc,
  output logic        pcrc_bit,
  output logic        pcrc_bit_vld,
  output logic        pcrc_done,
  output logic        busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [12:0] shadow;
  logic [3:0]  count;
  logic        abort;
  logic        fb;
  logic        calc_take;

  assign abort     = act_err_frm_tx | psv_err_frm_tx | arb_lost;
  assign fb        = tx_bit ^ pcrc[12];
  assign calc_take = tx_bit_en & (~tx_stuff_bit | INCL_STUFF);

  assign pcrc_bit     = (state == SEND) & shadow[12];
  assign pcrc_bit_vld = (state == SEND);
  assign busy         = (state == CALC) | (state == SEND);

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      state     <= IDLE;
      pcrc      <= 13'd0;
      shadow    <= 13'd0;
      count     <= 4'd0;
      pcrc_done <= 1'b0;
    end else begin
      pcrc_done <= 1'b0;
      if (abort || tx_success) begin
        state <= IDLE;
      end else if (tx_start) begin
        pcrc  <= INIT;
        count <= 4'd0;
        state <= CALC;
      end else begin
        case (state)
          CALC: begin
            // a strobe coinciding with pcrc_send belongs to the PCRC field, not the preface
            if (pcrc_send) begin
              shadow <= pcrc;
              state  <= SEND;
            end else if (calc_take) begin
              pcrc <= {pcrc[11:0], 1'b0} ^ (fb ? POLY : 13'd0);
            end
          end
          SEND: begin
            // stuff bits are inserted by the formatter and never consume a CRC bit
            if (tx_bit_en && !tx_stuff_bit) begin
              shadow <= {shadow[11:0], 1'b0};
              count  <= count + 4'd1;
              if (count == 4'd12) begin
                state     <= DONE;
                pcrc_done <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pcrc_generator.sv
// tb/tb_pcrc_generator.sv - self-checking bench for pcrc_generator
module tb_pcrc_generator;

  logic        clk = 1'b0;
  logic        g_rst = 1'b1;
  logic        tx_start = 1'b0;
  logic        tx_bit_en = 1'b0;
  logic        tx_bit = 1'b0;
  logic        tx_stuff_bit = 1'b0;
  logic        pcrc_send = 1'b0;
  logic        act_err_frm_tx = 1'b0;
  logic        psv_err_frm_tx = 1'b0;
  logic        arb_lost = 1'b0;
  logic        tx_success = 1'b0;

  logic [12:0] pcrc, pcrc_ns;
  logic        pcrc_bit, pcrc_bit_ns;
  logic        pcrc_bit_vld, pcrc_bit_vld_ns;
  logic        pcrc_done, pcrc_done_ns;
  logic        busy, busy_ns;

  int checks = 0;
  int errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  pcrc_generator #(.POLY(13'h1C1F), .INIT(13'h0000), .INCL_STUFF(1'b1)) u_dut (
    .clk(clk), .g_rst(g_rst), .tx_start(tx_start), .tx_bit_en(tx_bit_en), .tx_bit(tx_bit),
    .tx_stuff_bit(tx_stuff_bit), .pcrc_send(pcrc_send), .act_err_frm_tx(act_err_frm_tx),
    .psv_err_frm_tx(psv_err_frm_tx), .arb_lost(arb_lost), .tx_success(tx_success),
    .pcrc(pcrc), .pcrc_bit(pcrc_bit), .pcrc_bit_vld(pcrc_bit_vld), .pcrc_done(pcrc_done), .busy(busy)
  );

  pcrc_generator #(.POLY(13'h1C1F), .INIT(13'h0000), .INCL_STUFF(1'b0)) u_ns (
    .clk(clk), .g_rst(g_rst), .tx_start(tx_start), .tx_bit_en(tx_bit_en), .tx_bit(tx_bit),
    .tx_stuff_bit(tx_stuff_bit), .pcrc_send(pcrc_send), .act_err_frm_tx(act_err_frm_tx),
    .psv_err_frm_tx(psv_err_frm_tx), .arb_lost(arb_lost), .tx_success(tx_success),
    .pcrc(pcrc_ns), .pcrc_bit(pcrc_bit_ns), .pcrc_bit_vld(pcrc_bit_vld_ns), .pcrc_done(pcrc_done_ns), .busy(busy_ns)
  );

  function automatic logic [12:0] crc_step(input logic [12:0] c, input logic b);
    logic [12:0] n;
    n = {c[11:0], 1'b0};
    if (b ^ c[12]) n = n ^ 13'h1C1F;
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    tx_start = 1'b1; tick(); tx_start = 1'b0;
  endtask

  task automatic do_send();
    pcrc_send = 1'b1; tick(); pcrc_send = 1'b0;
  endtask

  task automatic strobe(input logic b, input logic s);
    tx_bit_en = 1'b1; tx_bit = b; tx_stuff_bit = s;
    tick();
    tx_bit_en = 1'b0; tx_stuff_bit = 1'b0; tx_bit = 1'b0;
  endtask

  task automatic finish_frame();
    tx_success = 1'b1; tick(); tx_success = 1'b0;
  endtask

  // Pushes the frozen CRC MSB-first, then pops one bit per serial strobe.
  task automatic serialise(input logic [12:0] val, input int nbits, input bit stuff_en);
    logic e;
    for (int i = 12; i >= 0; i--) exp_q.push_back(val[i]);
    for (int i = 0; i < nbits; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (pcrc_bit_vld !== 1'b1 || pcrc_bit !== e) begin
        errors++;
        $display("FAIL serial_bit[%0d]: got vld=%b bit=%b, need vld=1 bit=%b", i, pcrc_bit_vld, pcrc_bit, e);
      end
      if (stuff_en && $urandom_range(0, 2) == 0) strobe(~e, 1'b1);
      checks++;
      if (pcrc_done !== 1'b0) begin
        errors++;
        $display("FAIL early_done[%0d]: got %b, need 0", i, pcrc_done);
      end
      strobe(1'b0, 1'b0);
    end
    if (nbits == 13) begin
      checks++;
      if (pcrc_done !== 1'b1 || pcrc_bit_vld !== 1'b0 || pcrc !== val) begin
        errors++;
        $display("FAIL done_pulse: got done=%b vld=%b pcrc=%h, need done=1 vld=0 pcrc=%h", pcrc_done, pcrc_bit_vld, pcrc, val);
      end
      tick();
      checks++;
      if (pcrc_done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL done_width: got done=%b busy=%b, need 0 0", pcrc_done, busy);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (pcrc !== 13'd0 || pcrc_bit !== 1'b0 || pcrc_bit_vld !== 1'b0 || pcrc_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pcrc=%h bit=%b vld=%b done=%b busy=%b, need all 0", pcrc, pcrc_bit, pcrc_bit_vld, pcrc_done, busy);
    end
    tick(); g_rst = 1'b0; tick();
  endtask

  task automatic test_single_bit();
    do_start();
    checks++;
    if (busy !== 1'b1 || pcrc_bit_vld !== 1'b0) begin
      errors++;
      $display("FAIL calc_busy: got busy=%b vld=%b, need 1 0", busy, pcrc_bit_vld);
    end
    strobe(1'b1, 1'b0);
    checks++;
    if (pcrc !== 13'h1C1F) begin
      errors++;
      $display("FAIL one_bit_crc: got %h, need 1c1f", pcrc);
    end
    do_send();
    serialise(13'h1C1F, 13, 1'b0);
  endtask

  task automatic test_two_bits();
    do_start();
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b0);
    checks++;
    if (pcrc !== 13'h0421) begin
      errors++;
      $display("FAIL two_bit_crc: got %h, need 0421", pcrc);
    end
    finish_frame();
    checks++;
    if (busy !== 1'b0 || pcrc !== 13'h0421) begin
      errors++;
      $display("FAIL tx_success_hold: got busy=%b pcrc=%h, need 0 0421", busy, pcrc);
    end
  endtask

  task automatic test_zeros();
    do_start();
    for (int i = 0; i < 20; i++) strobe(1'b0, 1'b0);
    checks++;
    if (pcrc !== 13'h0000) begin
      errors++;
      $display("FAIL zeros_crc: got %h, need 0000", pcrc);
    end
    do_send();
    serialise(13'h0000, 13, 1'b0);
    do_start();
    do_send();
    serialise(13'h0000, 13, 1'b0);
  endtask

  task automatic test_stuff();
    do_start();
    strobe(1'b1, 1'b0);
    strobe(1'b0, 1'b1);
    checks++;
    if (pcrc_ns !== 13'h1C1F || pcrc !== 13'h0421) begin
      errors++;
      $display("FAIL stuff_rule: got excl=%h incl=%h, need 1c1f 0421", pcrc_ns, pcrc);
    end
    finish_frame();
  endtask

  task automatic test_abort();
    logic [12:0] e;
    e = crc_step(crc_step(crc_step(13'h0, 1'b1), 1'b0), 1'b1);
    do_start();
    strobe(1'b1, 1'b0); strobe(1'b0, 1'b0); strobe(1'b1, 1'b0);
    do_send();
    serialise(e, 5, 1'b0);
    act_err_frm_tx = 1'b1; tick(); act_err_frm_tx = 1'b0;
    checks++;
    if (pcrc_bit_vld !== 1'b0 || busy !== 1'b0 || pcrc_done !== 1'b0 || pcrc !== e) begin
      errors++;
      $display("FAIL act_err_abort: got vld=%b busy=%b done=%b pcrc=%h, need 0 0 0 %h", pcrc_bit_vld, busy, pcrc_done, pcrc, e);
    end
    strobe(1'b0, 1'b0);
    checks++;
    if (pcrc_done !== 1'b0 || pcrc_bit_vld !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got done=%b vld=%b, need 0 0", pcrc_done, pcrc_bit_vld);
    end
    do_start();
    strobe(1'b1, 1'b0);
    do_send();
    serialise(13'h1C1F, 5, 1'b0);
    arb_lost = 1'b1; tick(); arb_lost = 1'b0;
    checks++;
    if (pcrc_bit_vld !== 1'b0 || busy !== 1'b0 || pcrc_done !== 1'b0 || pcrc !== 13'h1C1F) begin
      errors++;
      $display("FAIL arb_lost_abort: got vld=%b busy=%b done=%b pcrc=%h, need 0 0 0 1c1f", pcrc_bit_vld, busy, pcrc_done, pcrc);
    end
    do_start();
    strobe(1'b1, 1'b0);
    do_send();
    serialise(13'h1C1F, 5, 1'b0);
    g_rst = 1'b1;
    #1;
    checks++;
    if (pcrc !== 13'd0 || pcrc_bit !== 1'b0 || pcrc_bit_vld !== 1'b0 || pcrc_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_send: got pcrc=%h bit=%b vld=%b done=%b busy=%b, need all 0", pcrc, pcrc_bit, pcrc_bit_vld, pcrc_done, busy);
    end
    tick(); g_rst = 1'b0; tick();
  endtask

  task automatic test_same_cycle();
    do_send();
    checks++;
    if (pcrc_bit_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL send_in_idle: got vld=%b busy=%b, need 0 0", pcrc_bit_vld, busy);
    end
    do_start();
    strobe(1'b1, 1'b0);
    pcrc_send = 1'b1; tx_bit_en = 1'b1; tx_bit = 1'b1;
    tick();
    pcrc_send = 1'b0; tx_bit_en = 1'b0; tx_bit = 1'b0;
    checks++;
    if (pcrc !== 13'h1C1F) begin
      errors++;
      $display("FAIL send_with_strobe: got %h, need 1c1f", pcrc);
    end
    serialise(13'h1C1F, 13, 1'b0);
    tx_start = 1'b1; pcrc_send = 1'b1;
    tick();
    tx_start = 1'b0; pcrc_send = 1'b0;
    checks++;
    if (pcrc !== 13'h0000 || busy !== 1'b1 || pcrc_bit_vld !== 1'b0) begin
      errors++;
      $display("FAIL start_and_send: got pcrc=%h busy=%b vld=%b, need 0000 1 0", pcrc, busy, pcrc_bit_vld);
    end
    finish_frame();
  endtask

  task automatic test_back_to_back();
    logic [12:0] ei, en;
    logic b, s;
    int n;
    for (int f = 0; f < 4; f++) begin
      ei = 13'h0; en = 13'h0;
      n = $urandom_range(1, 30);
      do_start();
      for (int i = 0; i < n; i++) begin
        b = 1'($urandom_range(0, 1));
        s = ($urandom_range(0, 3) == 0);
        ei = crc_step(ei, b);
        if (!s) en = crc_step(en, b);
        strobe(b, s);
      end
      checks++;
      if (pcrc !== ei || pcrc_ns !== en) begin
        errors++;
        $display("FAIL random_crc[%0d]: got incl=%h excl=%h, need %h %h", f, pcrc, pcrc_ns, ei, en);
      end
      do_send();
      serialise(ei, 13, 1'b1);
      checks++;
      if (pcrc_ns !== en) begin
        errors++;
        $display("FAIL random_frozen[%0d]: got %h, need %h", f, pcrc_ns, en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_two_bits();
    test_zeros();
    test_stuff();
    test_abort();
    test_same_cycle();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcrc_generator.md
Name: pcrc_generator

Overview:
- Transmit-side preface-CRC (PCRC) engine for the CAN XL controller; counterpart of the receive-side PCRC comparison.
- Accumulates a 13-bit CRC bit-serially over the transmitted preface bits.
- Freezes the result at the start of the PCRC field and serialises it MSB-first to the bit-stream formatter, one bit per sample strobe.
- Aborts cleanly on error-frame transmission or arbitration loss.

Parameters:
POLY, 13'h1C1F, generator polynomial without the implicit x^13 term
INIT, 13'h0000, CRC register value loaded on tx_start
INCL_STUFF, 1, 1 = stuff bits enter the CRC; 0 = stuff bits are skipped

Ports:
clk  input  1  system clock
g_rst  input  1  asynchronous active-high reset
tx_start  input  1  one-cycle pulse at start of frame; loads INIT and enters CALC
tx_bit_en  input  1  one-cycle strobe per transmitted bit time
tx_bit  input  1  transmitted bit value, qualified by tx_bit_en
tx_stuff_bit  input  1  current tx_bit is a stuff bit
pcrc_send  input  1  one-cycle pulse: freeze CRC, begin serialising
act_err_frm_tx  input  1  active error frame being sent (abort)
psv_err_frm_tx  input  1  passive error frame being sent (abort)
arb_lost  input  1  arbitration lost (abort)
tx_success  input  1  frame completed; return to IDLE
pcrc  output  13  accumulated/frozen CRC value
pcrc_bit  output  1  current serial CRC bit
pcrc_bit_vld  output  1  high while in SEND
pcrc_done  output  1  one-cycle pulse after the 13th bit is shifted
busy  output  1  high in CALC or SEND

Behaviour:
- Clock and reset: one clock, clk. Reset is g_rst, asynchronous and active-high.
- Reset values: state=IDLE; pcrc=0; pcrc_bit=0; pcrc_bit_vld=0; pcrc_done=0; busy=0; bit count=0.
- States: IDLE, CALC, SEND, DONE.
- Priority each cycle, highest first: abort (act_err_frm_tx | psv_err_frm_tx | arb_lost) or tx_success; then tx_start; then pcrc_send; then tx_bit_en.
- Abort / tx_success: go to IDLE from any state. pcrc is held; pcrc_bit_vld=0; no pcrc_done.
- tx_start, any state: pcrc<=INIT; count<=0; go to CALC.
- CALC update: on tx_bit_en, and only if (!tx_stuff_bit | INCL_STUFF):
  - fb = tx_bit ^ pcrc[12]
  - pcrc <= {pcrc[11:0],1'b0} ^ (fb ? POLY : 0)
  - Result visible the cycle after the strobe. A strobe excluded by the stuff rule leaves pcrc unchanged.
- CALC, pcrc_send: copy pcrc into the shadow shift register and go to SEND. A tx_bit_en in the same cycle is ignored (not accumulated). pcrc_send outside CALC is ignored.
- SEND outputs: pcrc_bit = shadow[12], valid from the cycle after pcrc_send; pcrc_bit_vld=1; pcrc frozen.
- SEND strobe: each tx_bit_en shifts shadow left by one and increments count (4-bit).
- SEND exit: on the strobe that brings count to 13, go to DONE and pulse pcrc_done for exactly one cycle. pcrc_bit_vld drops in the same cycle.
- DONE: pcrc holds the final value. tx_start, abort or tx_success leave it.
- Stuff bits during SEND: tx_stuff_bit strobes do not advance the serialiser, independent of INCL_STUFF. The formatter inserts the stuff bit itself.
- Latency: one cycle from strobe to updated pcrc or pcrc_bit.
- Zero-length input: pcrc_send straight after tx_start emits INIT.
- Reset mid-SEND: immediate IDLE, all outputs at reset values.

Test Plan:
- tx_start; one strobe tx_bit=1; pcrc_send; 13 strobes -> pcrc=13'h1C1F; serial bits 1,1,1,0,0,0,0,0,1,1,1,1,1; pcrc_done one cycle after the 13th strobe.
- tx_start; bits 1,0 -> pcrc=13'h0421 after the second strobe.
- tx_start; 20 strobes tx_bit=0 -> pcrc stays 13'h0000; serial output is 13 zeros.
- INCL_STUFF=0: bits 1 then stuff bit 0 -> pcrc=13'h1C1F. Same stimulus with INCL_STUFF=1 -> 13'h0421.
- In SEND after 5 bits, assert act_err_frm_tx -> IDLE next cycle, pcrc_bit_vld=0, no pcrc_done. The same check with arb_lost and with g_rst mid-SEND -> all outputs at reset values.
- pcrc_send and tx_bit_en=1 with tx_bit=1 in the same cycle -> bit not accumulated. tx_start and pcrc_send together -> pcrc=INIT, state CALC.
